// File: rtl/kugelblitz_rewrite_ctrl.sv
// kugelblitz rewrite rule controller: shadow/active rule tables,
// frame-boundary commit and per-port frame/rewrite statistics.
module kugelblitz_rewrite_ctrl #(
  parameter int RULE_COUNT   = 4,
  parameter int KEEP_WIDTH   = 64,
  parameter int OFFSET_WIDTH = 6,
  parameter int IDX_WIDTH    = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_wr_en,
  input  logic [IDX_WIDTH-1:0]               cfg_wr_idx,
  input  logic                               cfg_wr_enable,
  input  logic [OFFSET_WIDTH-1:0]            cfg_wr_offset,
  input  logic [7:0]                         cfg_wr_data,
  input  logic                               cfg_commit,
  output logic                               cfg_commit_pending,
  input  logic                               mon_tvalid,
  input  logic                               mon_tready,
  input  logic                               mon_tlast,
  output logic [RULE_COUNT-1:0]              rw_valid,
  output logic [RULE_COUNT*OFFSET_WIDTH-1:0] rw_offset,
  output logic [RULE_COUNT*8-1:0]            rw_data,
  input  logic                               stat_clr,
  output logic [CNT_WIDTH-1:0]               stat_frames,
  output logic [CNT_WIDTH-1:0]               stat_rewrites
);

  if (OFFSET_WIDTH != $clog2(KEEP_WIDTH)) begin : g_chk_off
    $error("OFFSET_WIDTH must equal clog2(KEEP_WIDTH)");
  end
  if (IDX_WIDTH != $clog2(RULE_COUNT)) begin : g_chk_idx
    $error("IDX_WIDTH must equal clog2(RULE_COUNT)");
  end

  typedef enum logic {
    SOF = 1'b0,
    MID = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t state, state_nxt;

  logic [RULE_COUNT-1:0]                   sh_en, act_en;
  logic [RULE_COUNT-1:0][OFFSET_WIDTH-1:0] sh_off, act_off;
  logic [RULE_COUNT-1:0][7:0]              sh_dat, act_dat;
  logic                                    pending;

  logic hs;
  logic eof;
  logic apply;

  assign hs  = mon_tvalid & mon_tready;
  assign eof = hs & mon_tlast;
  // An idle SOF cycle or any frame end is a safe point to swap tables.
  assign apply = pending & (((state == SOF) & ~hs) | eof);

  always_comb begin
    state_nxt = state;
    unique case (state)
      SOF: if (hs & ~mon_tlast) state_nxt = MID;
      MID: if (eof) state_nxt = SOF;
      default: state_nxt = SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SOF;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_en  <= '0;
      sh_off <= '0;
      sh_dat <= '0;
    end else if (cfg_wr_en) begin
      sh_en[cfg_wr_idx]  <= cfg_wr_enable;
      sh_off[cfg_wr_idx] <= cfg_wr_offset;
      sh_dat[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  // Active table copies the registered shadow, so a same-cycle write misses it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_en  <= '0;
      act_off <= '0;
      act_dat <= '0;
    end else if (apply) begin
      act_en  <= sh_en;
      act_off <= sh_off;
      act_dat <= sh_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          pending <= 1'b0;
    else if (cfg_commit) pending <= 1'b1;
    else if (apply)      pending <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        stat_frames <= '0;
    else if (stat_clr) stat_frames <= '0;
    else if (eof)      stat_frames <= stat_frames + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stat_rewrites <= '0;
    else if (stat_clr)
      stat_rewrites <= '0;
    else if (hs && state == SOF && |act_en)
      stat_rewrites <= stat_rewrites + CNT_ONE;
  end

  assign cfg_commit_pending = pending;
  assign rw_valid  = act_en & {RULE_COUNT{state == SOF}};
  assign rw_offset = act_off;
  assign rw_data   = act_dat;

endmodule

// File: tb/tb_kugelblitz_rewrite_ctrl.sv
// Directed scoreboard bench for kugelblitz_rewrite_ctrl.
// Stimulus queues expected observations; a negedge monitor checks them.
module tb_kugelblitz_rewrite_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_idx;
  logic        cfg_wr_enable;
  logic [5:0]  cfg_wr_offset;
  logic [7:0]  cfg_wr_data;
  logic        cfg_commit;
  logic        cfg_commit_pending;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;
  logic [3:0]  rw_valid;
  logic [23:0] rw_offset;
  logic [31:0] rw_data;
  logic        stat_clr;
  logic [31:0] stat_frames;
  logic [31:0] stat_rewrites;

  kugelblitz_rewrite_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_wr_en          (cfg_wr_en),
    .cfg_wr_idx         (cfg_wr_idx),
    .cfg_wr_enable      (cfg_wr_enable),
    .cfg_wr_offset      (cfg_wr_offset),
    .cfg_wr_data        (cfg_wr_data),
    .cfg_commit         (cfg_commit),
    .cfg_commit_pending (cfg_commit_pending),
    .mon_tvalid         (mon_tvalid),
    .mon_tready         (mon_tready),
    .mon_tlast          (mon_tlast),
    .rw_valid           (rw_valid),
    .rw_offset          (rw_offset),
    .rw_data            (rw_data),
    .stat_clr           (stat_clr),
    .stat_frames        (stat_frames),
    .stat_rewrites      (stat_rewrites)
  );

  always #5 clk = ~clk;

  typedef enum {F_PEND, F_RWV, F_OFF, F_DAT, F_FR, F_RW} fld_t;

  typedef struct {
    string       name;
    fld_t        fld;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      act = '0;
      case (e.fld)
        F_PEND: act = {31'b0, cfg_commit_pending};
        F_RWV:  act = {28'b0, rw_valid};
        F_OFF:  act = {8'b0, rw_offset};
        F_DAT:  act = rw_data;
        F_FR:   act = stat_frames;
        F_RW:   act = stat_rewrites;
        default: act = 'x;
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  task automatic chk(input string n, input fld_t f, input logic [31:0] v);
    q.push_back('{n, f, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_wr_en     = 1'b0;
    cfg_wr_idx    = '0;
    cfg_wr_enable = 1'b0;
    cfg_wr_offset = '0;
    cfg_wr_data   = '0;
    cfg_commit    = 1'b0;
    mon_tvalid    = 1'b0;
    mon_tready    = 1'b0;
    mon_tlast     = 1'b0;
    stat_clr      = 1'b0;
  endtask

  task automatic beat(input logic last);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = last;
  endtask

  task automatic wr(input logic [1:0] idx, input logic en,
                    input logic [5:0] off, input logic [7:0] d);
    cfg_wr_en     = 1'b1;
    cfg_wr_idx    = idx;
    cfg_wr_enable = en;
    cfg_wr_offset = off;
    cfg_wr_data   = d;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset defaults, then a single-beat frame with no rules
    chk("rst_pend", F_PEND, 0);
    chk("rst_rwv", F_RWV, 0);
    chk("rst_off", F_OFF, 0);
    chk("rst_dat", F_DAT, 0);
    chk("rst_fr", F_FR, 0);
    chk("rst_rw", F_RW, 0);
    beat(1'b1);
    tick();
    idle();
    chk("b1_fr", F_FR, 1);
    chk("b1_rw", F_RW, 0);

    // basic commit while idle
    wr(2'd0, 1'b1, 6'd12, 8'h5A);
    tick();
    idle();
    cfg_commit = 1'b1;
    chk("bc_pend_t", F_PEND, 0);
    tick();
    idle();
    chk("bc_pend_t1", F_PEND, 1);
    chk("bc_rwv_t1", F_RWV, 0);
    tick();
    chk("bc_pend_t2", F_PEND, 0);
    chk("bc_rwv_t2", F_RWV, 32'h1);
    chk("bc_off", F_OFF, 32'd12);
    chk("bc_dat", F_DAT, 32'h5A);

    // three-beat frame, commit issued in beat 2
    beat(1'b0);
    tick();
    wr(2'd1, 1'b1, 6'd33, 8'hC3);
    cfg_commit = 1'b1;
    beat(1'b0);
    chk("mf_rwv_b2", F_RWV, 0);
    tick();
    idle();
    beat(1'b1);
    chk("mf_pend_b3", F_PEND, 1);
    chk("mf_rwv_b3", F_RWV, 0);
    tick();
    idle();
    chk("mf_pend_nxt", F_PEND, 0);
    chk("mf_rwv_nxt", F_RWV, 32'h3);
    chk("mf_off", F_OFF, 32'd2124);
    chk("mf_dat", F_DAT, 32'hC35A);
    chk("mf_fr", F_FR, 2);
    chk("mf_rw", F_RW, 1);
    tick();

    // back-to-back single-beat frames with a commit pending
    wr(2'd2, 1'b1, 6'd63, 8'hFF);
    tick();
    idle();
    cfg_commit = 1'b1;
    tick();
    idle();
    beat(1'b1);
    chk("bb_pend_1", F_PEND, 1);
    chk("bb_rwv_1", F_RWV, 32'h3);
    chk("bb_fr_1", F_FR, 2);
    tick();
    chk("bb_pend_2", F_PEND, 0);
    chk("bb_rwv_2", F_RWV, 32'h7);
    chk("bb_fr_2", F_FR, 3);
    chk("bb_rw_2", F_RW, 2);
    tick();
    chk("bb_fr_3", F_FR, 4);
    chk("bb_rw_3", F_RW, 3);
    tick();
    idle();
    chk("bb_fr_end", F_FR, 5);
    chk("bb_rw_end", F_RW, 4);
    chk("bb_off", F_OFF, 32'd260172);
    chk("bb_dat", F_DAT, 32'hFFC35A);

    // commit and shadow write coincident with an apply
    cfg_commit = 1'b1;
    tick();
    idle();
    chk("se_pend_a", F_PEND, 1);
    cfg_commit = 1'b1;
    wr(2'd3, 1'b1, 6'd5, 8'h11);
    tick();
    idle();
    chk("se_pend_re", F_PEND, 1);
    chk("se_rwv_excl", F_RWV, 32'h7);
    tick();
    chk("se_pend_done", F_PEND, 0);
    chk("se_rwv_all", F_RWV, 32'hF);
    chk("se_off", F_OFF, 32'd1570892);
    chk("se_dat", F_DAT, 32'h11FFC35A);

    // stat_clr coincident with an end of frame
    beat(1'b1);
    stat_clr = 1'b1;
    tick();
    idle();
    chk("clr_fr", F_FR, 0);
    chk("clr_rw", F_RW, 0);
    beat(1'b1);
    tick();
    idle();
    chk("clr_fr_inc", F_FR, 1);
    chk("clr_rw_inc", F_RW, 1);

    // reset in beat 2 of a frame with a commit pending
    beat(1'b0);
    cfg_commit = 1'b1;
    tick();
    idle();
    beat(1'b0);
    chk("rm_pend_b2", F_PEND, 1);
    chk("rm_rwv_b2", F_RWV, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    beat(1'b0);
    chk("rm_pend", F_PEND, 0);
    chk("rm_rwv", F_RWV, 0);
    chk("rm_off", F_OFF, 0);
    chk("rm_dat", F_DAT, 0);
    chk("rm_fr", F_FR, 0);
    tick();
    idle();
    beat(1'b1);
    chk("rm_rw", F_RW, 0);
    tick();
    idle();
    chk("rm_fr_end", F_FR, 1);
    chk("rm_rw_end", F_RW, 0);

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
